// File: rtl/storage_pkg.sv
// storage_pkg: shared request type, FSM states and address-map constants for the storage adapter
package storage_pkg;
    localparam int          STORAGE_MEM_W = 32;
    localparam int          STORAGE_BE_W  = STORAGE_MEM_W / 8;
    localparam logic [31:0] SRAM_LIMIT    = 32'h0000_0FFF;

    typedef enum logic [1:0] {IDLE, BUSY, GAP, DRAIN} adapter_state_e;

    typedef struct packed {
        logic                     we;
        logic [STORAGE_BE_W-1:0]  be;
        logic [31:0]              addr;
        logic [STORAGE_MEM_W-1:0] wdata;
    } storage_req_t;
endpackage

// File: rtl/storage_req_fifo.sv
// storage_req_fifo: synchronous request FIFO with wrap-bit pointers for full/empty detection
module storage_req_fifo
    import storage_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  storage_req_t push_data,
    output storage_req_t head,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    storage_req_t  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;

    // pointers advance by one per push/pop; the extra bit tells full from empty
    always_comb begin
        wr_ptr_d = wr_ptr_q + PW'(push);
        rd_ptr_d = rd_ptr_q + PW'(pop);
    end

    // pointer registers
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // entry storage, contents are don't-care until written
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
    end

    assign head  = mem_q[rd_ptr_q[AW-1:0]];
    assign empty = wr_ptr_q == rd_ptr_q;
    assign full  = wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0] && wr_ptr_q[AW] != rd_ptr_q[AW];
endmodule

// File: rtl/storage_request_adapter.sv
// storage_request_adapter: queues core requests and issues them one at a time to the storage controller
// Define STORAGE_ADAPTER_TIMEOUT_EN to error out accesses stuck in BUSY for TIMEOUT_CYCLES.
module storage_request_adapter
    import storage_pkg::*;
#(
    parameter int MEM_W          = STORAGE_MEM_W,
    parameter int REQ_DEPTH      = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               prog_mode,
    input  logic               core_req,
    output logic               core_gnt,
    input  logic               core_we,
    input  logic [MEM_W/8-1:0] core_be,
    input  logic [31:0]        core_addr,
    input  logic [MEM_W-1:0]   core_wdata,
    output logic               core_rvalid,
    output logic [MEM_W-1:0]   core_rdata,
    output logic               core_err,
    output logic               memory_access,
    output logic               memory_is_writing,
    output logic [31:0]        addr,
    output logic [31:0]        d_in,
    output logic [MEM_W/8-1:0] mem_be,
    input  logic [31:0]        d_out,
    input  logic               out_valid
);
    storage_req_t       push_req, head;
    adapter_state_e     state_q, state_d;
    logic               full, empty, pop, misaligned, start, done, timeout;
    logic               rvalid_q, rvalid_d, err_q, err_d, ma_q, ma_d, we_q, we_d;
    logic [MEM_W-1:0]   rdata_q, rdata_d;
    logic [31:0]        addr_q, addr_d, din_q, din_d;
    logic [MEM_W/8-1:0] be_q, be_d;

    assign core_gnt   = !full && !prog_mode;
    assign push_req   = '{we: core_we, be: core_be, addr: core_addr, wdata: core_wdata};
    assign pop        = state_q == IDLE && !empty && !prog_mode;
    assign misaligned = head.addr[1:0] != 2'b00;
    assign start      = pop && !misaligned;
    assign done       = state_q == BUSY && out_valid;

    storage_req_fifo #(.DEPTH(REQ_DEPTH)) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (core_req && core_gnt),
        .pop      (pop),
        .push_data(push_req),
        .head     (head),
        .full     (full),
        .empty    (empty)
    );

`ifdef STORAGE_ADAPTER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // counts BUSY cycles of the current access, cleared when it is issued
    always_comb cnt_d = start ? '0 : state_q == BUSY ? cnt_q + CNT_W'(1) : cnt_q;

    // timeout counter register
    always_ff @(posedge clk) cnt_q <= rst ? '0 : cnt_d;

    assign timeout = state_q == BUSY && !out_valid && cnt_q == CNT_W'(TIMEOUT_CYCLES - 1);
`else
    assign timeout = 1'b0;
`endif

    // state register
    always_ff @(posedge clk) state_q <= rst ? IDLE : state_d;

    // next state; GAP forces one idle cycle between accesses, DRAIN absorbs a timed-out access
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = start ? BUSY : IDLE;
            BUSY:    state_d = out_valid ? GAP : timeout ? DRAIN : BUSY;
            GAP:     state_d = IDLE;
            default: state_d = out_valid ? GAP : DRAIN;
        endcase
    end

    // response pulse and storage-port values; storage outputs only change on issue
    always_comb begin
        rvalid_d = (pop && misaligned) || done || timeout;
        err_d    = (pop && misaligned) || timeout;
        rdata_d  = done && !we_q ? MEM_W'(d_out) : '0;
        ma_d     = start ? 1'b1 : (done || (state_q == DRAIN && out_valid)) ? 1'b0 : ma_q;
        we_d     = start ? head.we : we_q;
        addr_d   = start ? head.addr : addr_q;
        din_d    = start ? head.wdata : din_q;
        be_d     = start ? head.be : be_q;
    end

    // output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
            ma_q     <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            din_q    <= '0;
            be_q     <= '0;
        end else begin
            rvalid_q <= rvalid_d;
            err_q    <= err_d;
            rdata_q  <= rdata_d;
            ma_q     <= ma_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            din_q    <= din_d;
            be_q     <= be_d;
        end
    end

    assign core_rvalid       = rvalid_q;
    assign core_err          = err_q;
    assign core_rdata        = rdata_q;
    assign memory_access     = ma_q;
    assign memory_is_writing = we_q;
    assign addr              = addr_q;
    assign d_in              = din_q;
    assign mem_be            = be_q;
endmodule
